// File: rtl/addn_pkg.sv
// Shared types and constants for the chunk-serial adder (addn_seq).
// The optional subtract mode is enabled with the ADDN_SUB_EN macro in addn_seq.
package addn_pkg;

    localparam int ADDN_WIDTH = 32;
    localparam int ADDN_CHUNK = 8;

    typedef enum logic [1:0] {
        ADDN_IDLE,
        ADDN_RUN,
        ADDN_DONE
    } addn_state_e;

    // Step counter width; a single-step configuration still needs one bit.
    function automatic int addn_step_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/addn_seq_add_chunk.sv
// Combinational CHUNK-bit ripple adder built from per-bit full-adder cells.
// Also exposes the carry into the slice MSB so the caller can derive signed overflow.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/addn_seq.sv
// Chunk-serial WIDTH-bit adder with valid/ready on both sides; one CHUNK slice per cycle.
// Define ADDN_SUB_EN to add the sub port (a - b - cin using inverted b and carry-in).
module addn_seq
    import addn_pkg::*;
#(
    parameter int WIDTH = ADDN_WIDTH,
    parameter int CHUNK = ADDN_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDN_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS  = WIDTH / CHUNK;
    localparam int STEP_W = addn_step_w(STEPS);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    addn_state_e       state;
    addn_state_e       state_next;
    logic [STEP_W-1:0] step;
    logic              carry;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_cmsb;
    logic [WIDTH-1:0]  sum_shift;
    logic              last_step;
    logic              accept;

`ifdef ADDN_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last_step = (step == LAST_STEP);
    assign accept    = (state == ADDN_IDLE) && in_valid;
    assign in_ready  = (state == ADDN_IDLE);
    assign out_valid = (state == ADDN_DONE);

    // Operands shift right each step, so the active slice always sits in the low CHUNK bits.
    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (opa[CHUNK-1:0]),
        .b    (opb[CHUNK-1:0]),
        .cin  (carry),
        .s    (slice_sum),
        .cout (slice_cout),
        .cmsb (slice_cmsb)
    );

    // New slices enter at the top; after STEPS shifts the first slice lands at bit 0.
    assign sum_shift = WIDTH'({slice_sum, sum} >> CHUNK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ADDN_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ADDN_IDLE: if (in_valid)  state_next = ADDN_RUN;
            ADDN_RUN:  if (last_step) state_next = ADDN_DONE;
            ADDN_DONE: if (out_ready) state_next = ADDN_IDLE;
            default:                  state_next = ADDN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            step  <= '0;
            carry <= cin_eff;
        end else if (state == ADDN_RUN) begin
            carry <= slice_cout;
            sum   <= sum_shift;
            if (last_step) begin
                cout <= slice_cout;
                ovf  <= slice_cmsb ^ slice_cout;
            end else begin
                step <= step + STEP_W'(1);
            end
        end
    end

    // Operand holding registers carry no state worth resetting.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa <= a;
            opb <= b_eff;
        end else if (state == ADDN_RUN) begin
            opa <= opa >> CHUNK;
            opb <= opb >> CHUNK;
        end
    end

endmodule

// File: tb/tb_addn_seq.sv
// Self-checking bench for addn_seq: directed vector table, back-pressure and reset
// sequences, optional ADDN_SUB_EN checks, and a CHUNK=32 / CHUNK=1 random sweep.
module tb_addn_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        cin   = 1'b0;
    logic        sub   = 1'b0;
    logic [2:0]  iv    = '0;
    logic [2:0]  ordy  = '0;
    logic [2:0]  ir, ov, co, of;
    logic [31:0] sm0, sm1, sm2;
    int          n_checks = 0;
    int          n_fail   = 0;

`ifdef ADDN_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    addn_seq #(.WIDTH(32), .CHUNK(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin),
`ifdef ADDN_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm0), .cout(co[0]), .ovf(of[0])
    );

    addn_seq #(.WIDTH(32), .CHUNK(32)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin),
`ifdef ADDN_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm1), .cout(co[1]), .ovf(of[1])
    );

    addn_seq #(.WIDTH(32), .CHUNK(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a), .b(b), .cin(cin),
`ifdef ADDN_SUB_EN
        .sub(sub),
`endif
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm2), .cout(co[2]), .ovf(of[2])
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    function automatic logic [31:0] sumof(input int k);
        case (k)
            0:       return sm0;
            1:       return sm1;
            default: return sm2;
        endcase
    endfunction

    // Reference: {ovf, cout, sum[31:0]}
    function automatic logic [33:0] model(input logic [31:0] aa, input logic [31:0] bb,
                                          input logic cc, input logic ss);
        logic [31:0] be;
        logic        ce;
        logic [32:0] r;
        logic        o;
        be = ss ? ~bb : bb;
        ce = ss ? ~cc : cc;
        r  = {1'b0, aa} + {1'b0, be} + {32'b0, ce};
        o  = (aa[31] == be[31]) && (r[31] != aa[31]);
        return {o, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!ov[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input int k, input logic [31:0] aa, input logic [31:0] bb,
                         input logic cc, input logic ss,
                         output logic [31:0] rs, output logic rc, output logic ro,
                         output int lat);
        int t;
        t = 0;
        while (!ir[k] && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_ready", 64'(ir[k]), 64'd1);
        a = aa; b = bb; cin = cc; sub = ss; iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k] = 1'b0;
        a = $urandom; b = $urandom; cin = ~cc; sub = ~ss;
        wait_valid(k, lat);
        rs = sumof(k);
        rc = co[k];
        ro = of[k];
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    initial begin
        vec_t        vecs[9];
        logic [31:0] rs;
        logic        rc, ro;
        int          lat;
        logic [33:0] m;
        logic [31:0] ra, rb;
        logic        rcin, rsub;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[8] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 32'h01000000, 1'b0, 1'b0};

        // Reset state
        #2;
        check("rst_out_valid", 64'(ov), 64'd0);
        check("rst_sum", 64'(sm0), 64'd0);
        check("rst_cout", 64'(co), 64'd0);
        check("rst_ovf", 64'(of), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(ir), 64'h7);

        // Directed vector table on CHUNK=8
        for (int i = 0; i < 9; i++) begin
            do_op(0, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, ro, lat);
            check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].c));
            check($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].o));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        // Back-pressure: result held in DONE, pending request ignored until IDLE
        a = 32'h7FFFFFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        wait_valid(0, lat);
        check("bp_latency", 64'(lat), 64'd4);
        a = 32'd5; b = 32'd3; cin = 1'b0; iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 64'(ov[0]), 64'd1);
            check("bp_sum", 64'(sm0), 64'h80000000);
            check("bp_cout", 64'(co[0]), 64'd0);
            check("bp_ovf", 64'(of[0]), 64'd1);
            check("bp_in_ready", 64'(ir[0]), 64'd0);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("bp_release_out_valid", 64'(ov[0]), 64'd0);
        check("bp_release_in_ready", 64'(ir[0]), 64'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("bp_second_accepted", 64'(ir[0]), 64'd0);
        wait_valid(0, lat);
        check("bp_second_latency", 64'(lat), 64'd4);
        check("bp_second_sum", 64'(sm0), 64'd8);
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;

        // Reset during RUN at step 2
        a = 32'h11111111; b = 32'h22222222; cin = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_running", 64'(ir[0]), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(ov[0]), 64'd0);
        check("mid_rst_sum", 64'(sm0), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(ir[0]), 64'd1);
        do_op(0, 32'd5, 32'd3, 1'b0, 1'b0, rs, rc, ro, lat);
        check("mid_rst_fresh_sum", 64'(rs), 64'd8);
        check("mid_rst_fresh_latency", 64'(lat), 64'd4);

`ifdef ADDN_SUB_EN
        do_op(0, 32'd5, 32'd7, 1'b0, 1'b1, rs, rc, ro, lat);
        check("sub_5m7_sum", 64'(rs), 64'hFFFFFFFE);
        check("sub_5m7_cout", 64'(rc), 64'd0);
        check("sub_5m7_ovf", 64'(ro), 64'd0);
        do_op(0, 32'h80000000, 32'd1, 1'b0, 1'b1, rs, rc, ro, lat);
        check("sub_min_sum", 64'(rs), 64'h7FFFFFFF);
        check("sub_min_cout", 64'(rc), 64'd1);
        check("sub_min_ovf", 64'(ro), 64'd1);
`endif

        // Parameter sweep: CHUNK=32 (1 step) and CHUNK=1 (32 steps)
        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                ra   = $urandom;
                rb   = $urandom;
                rcin = 1'($urandom_range(0, 1));
                rsub = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
                do_op(k, ra, rb, rcin, rsub, rs, rc, ro, lat);
                m = model(ra, rb, rcin, rsub);
                check($sformatf("sweep%0d_sum", k), 64'(rs), 64'(m[31:0]));
                check($sformatf("sweep%0d_cout", k), 64'(rc), 64'(m[32]));
                check($sformatf("sweep%0d_ovf", k), 64'(ro), 64'(m[33]));
                check($sformatf("sweep%0d_latency", k), 64'(lat), (k == 1) ? 64'd1 : 64'd32);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
